pipe_adder: RTL and testbench
=============================

PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: operand and result width in bits.
REQ-002 The block SHALL have parameter STAGES, default 4: pipeline depth; WIDTH SHALL be an integer multiple of STAGES; SLICE = WIDTH/STAGES.
REQ-003 The block SHALL have port clk, input, 1: single clock, rising edge.
REQ-004 The block SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 The block SHALL have port inp_a, input, WIDTH: operand A.
REQ-006 The block SHALL have port inp_b, input, WIDTH: operand B.
REQ-007 The block SHALL have port inp_cin, input, 1: carry-in, used in ADD only.
REQ-008 The block SHALL have port inp_sub, input, 1: operation select, 0 = ADD, 1 = SUB.
REQ-009 The block SHALL have port inp_valid, input, 1: upstream operand valid.
REQ-010 The block SHALL have port out_ready, output, 1: block accepts an operand this cycle.
REQ-011 The block SHALL have port out_sum, output, WIDTH: result.
REQ-012 The block SHALL have port out_carry, output, 1: carry-out; in SUB, 1 = no borrow.
REQ-013 The block SHALL have port out_overflow, output, 1: signed overflow (flags build only).
REQ-014 The block SHALL have port out_zero, output, 1: result equals zero (flags build only).
REQ-015 The block SHALL have port out_valid, output, 1: result valid.
REQ-016 The block SHALL have port inp_ready, input, 1: downstream accepts the result.

Function
REQ-017 ADD SHALL compute {out_carry, out_sum} = inp_a + inp_b + inp_cin, modulo 2^(WIDTH+1).
REQ-018 SUB SHALL compute inp_a + ~inp_b + 1; inp_cin is ignored.
REQ-019 Stage k (0..STAGES-1) SHALL add slice k of both operands plus the registered carry from stage k-1; stage 0 takes the carry-in.
REQ-020 Upper operand slices SHALL travel in skew registers, and completed lower result slices in alignment registers, so that the slices of each result emerge together.
REQ-021 An operand SHALL be accepted on a cycle with inp_valid=1 and out_ready=1.
REQ-022 The pipeline SHALL advance when the last stage is empty or inp_ready=1 (advance = !out_valid || inp_ready); out_ready SHALL equal advance.
REQ-023 Without stalls, out_valid SHALL rise exactly STAGES cycles after acceptance, with one result per cycle at full throughput.
REQ-024 While stalled, every stage SHALL hold its contents, and out_sum and all flags SHALL remain stable.
REQ-025 Results SHALL leave in acceptance order, with no loss or duplication.
REQ-026 When the pipeline advances with no accepted operand, a bubble SHALL be inserted (its valid bit is 0).
REQ-027 If a result is taken and a new operand accepted in the same cycle, both SHALL occur.

Reset
REQ-028 rst_n=0 SHALL asynchronously clear all stage valid bits, data, carries and flags; out_valid = 0, out_sum = 0, out_carry = 0, out_overflow = 0, out_zero = 0.
REQ-029 An assertion of rst_n with operations in flight SHALL discard them; no result from them SHALL appear after release.
REQ-030 The first acceptance SHALL be possible on the first rising edge after rst_n is released.

Configuration
REQ-031 With PIPE_ADDER_FLAGS_EN defined, out_overflow SHALL be set when the operand signs (B inverted in SUB) are equal and the result sign differs from them, and out_zero SHALL equal (out_sum == 0); both SHALL be registered alongside out_sum.
REQ-032 Without PIPE_ADDER_FLAGS_EN, out_overflow and out_zero SHALL be tied to 0, and no flag logic SHALL exist.

Structure
REQ-033 Package pipe_adder_pkg SHALL hold the OP_ADD/OP_SUB constants and the default WIDTH/STAGES values.
REQ-034 One sub-module, slice_adder, SHALL implement a registered SLICE-bit add with carry in and out and an enable, instantiated STAGES times.

Verification (WIDTH=32, STAGES=4)
REQ-035 Reset: rst_n=0 -> out_valid=0, out_sum=0, out_ready=1, asynchronously.
REQ-036 ADD with A=0xFFFFFFFF, B=1, cin=0 -> after 4 cycles out_sum=0, out_carry=1, out_zero=1.
REQ-037 SUB with A=5, B=7 -> out_sum=0xFFFFFFFE, out_carry=0, out_overflow=0.
REQ-038 ADD with A=0x7FFFFFFF, B=1 -> out_sum=0x80000000, out_overflow=1, out_carry=0.
REQ-039 Stall: 8 back-to-back ops with inp_ready=0 on cycles 3-5 -> in-order results, none lost, outputs stable, out_ready=0 while the last stage is full and stalled.
REQ-040 Reset mid-operation: rst_n pulsed low with 3 ops in flight -> out_valid=0 immediately, and no stale result after release.

Source files
------------

// File: rtl/pipe_adder_pkg.sv
// Shared constants for the pipelined adder: operation encoding and default geometry.
package pipe_adder_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int DEFAULT_WIDTH  = 32;
    localparam int DEFAULT_STAGES = 4;

endpackage

// File: rtl/pipe_adder_slice_adder.sv
// One pipeline stage worth of addition: a registered SLICE-bit add with carry in/out.
// sum_next exposes the unregistered slice sum for logic that must be captured
// alongside the registered result.
module slice_adder #(
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] sum_next,
    output logic [SLICE-1:0] sum,
    output logic             cout
);

    logic [SLICE-1:0] sum_d, sum_q;
    logic             cout_d, cout_q;

    // Slice add including the carry from the previous stage.
    always_comb begin
        {cout_d, sum_d} = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, cin};
    end

    // Capture the slice result only when the pipeline advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (en) begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign sum_next = sum_d;
    assign sum      = sum_q;
    assign cout     = cout_q;

endmodule

// File: rtl/pipe_adder.sv
// Pipelined ripple adder/subtractor split into STAGES slices of WIDTH/STAGES bits.
// Optional flag outputs (overflow, zero) are built when PIPE_ADDER_FLAGS_EN is defined;
// otherwise both flags are tied low.
//
// Handshake: an operand transfers on a rising edge where inp_valid && out_ready;
// a result transfers where out_valid && inp_ready. The whole pipeline moves as
// one when advance = !out_valid || inp_ready, and out_ready is exactly advance,
// so a taken result and a new operand can share the same edge.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] inp_a,
    input  logic [WIDTH-1:0] inp_b,
    input  logic             inp_cin,
    input  logic             inp_sub,
    input  logic             inp_valid,
    output logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_overflow,
    output logic             out_zero,
    output logic             out_valid,
    input  logic             inp_ready
);

    localparam int SLICE = WIDTH / STAGES;

    if (WIDTH % STAGES != 0) begin : g_bad_geometry
        $error("pipe_adder: WIDTH must be a multiple of STAGES");
    end

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    // Level k holds the operand skew (upper slices still to add), the aligned
    // lower result slices and the valid bit of the operation sitting there.
    logic [STAGES-1:0] valid_d, valid_q;
    logic [WIDTH-1:0]  a_d     [STAGES];
    logic [WIDTH-1:0]  a_q     [STAGES];
    logic [WIDTH-1:0]  b_d     [STAGES];
    logic [WIDTH-1:0]  b_q     [STAGES];
    logic [WIDTH-1:0]  align_d [STAGES];
    logic [WIDTH-1:0]  align_q [STAGES];
    logic [WIDTH-1:0]  res_lvl [STAGES];

    logic [SLICE-1:0]  slice_sum  [STAGES];
    logic [SLICE-1:0]  slice_next [STAGES];
    logic [STAGES-1:0] slice_cout;
    logic [STAGES-1:0] slice_cin;

    // Operation decode: SUB is A + ~B + 1, carry-in only matters for ADD.
    always_comb begin
        advance = !valid_q[STAGES-1] || inp_ready;
        b_eff   = (inp_sub == OP_SUB) ? ~inp_b : inp_b;
        cin_eff = (inp_sub == OP_SUB) ? 1'b1 : inp_cin;
    end

    // Next contents of every level: level 0 takes the new operand, level k
    // takes level k-1, with the freshly completed slice merged into the aligned result.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            res_lvl[k] = align_q[k];
            res_lvl[k][k*SLICE +: SLICE] = slice_sum[k];
        end
        valid_d[0] = inp_valid;
        a_d[0]     = inp_a;
        b_d[0]     = b_eff;
        align_d[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            valid_d[k] = valid_q[k-1];
            a_d[k]     = a_q[k-1];
            b_d[k]     = b_q[k-1];
            align_d[k] = res_lvl[k-1];
        end
    end

    // Level registers move together on advance and hold while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]     <= '0;
                b_q[k]     <= '0;
                align_q[k] <= '0;
            end
        end else if (advance) begin
            valid_q <= valid_d;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]     <= a_d[k];
                b_q[k]     <= b_d[k];
                align_q[k] <= align_d[k];
            end
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign slice_cin[k] = cin_eff;
        end else begin : g_rest
            assign slice_cin[k] = slice_cout[k-1];
        end

        slice_adder #(.SLICE(SLICE)) u_slice (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (advance),
            .a        (a_d[k][k*SLICE +: SLICE]),
            .b        (b_d[k][k*SLICE +: SLICE]),
            .cin      (slice_cin[k]),
            .sum_next (slice_next[k]),
            .sum      (slice_sum[k]),
            .cout     (slice_cout[k])
        );
    end

    assign out_ready = advance;
    assign out_valid = valid_q[STAGES-1];
    assign out_sum   = res_lvl[STAGES-1];
    assign out_carry = slice_cout[STAGES-1];

`ifdef PIPE_ADDER_FLAGS_EN
    logic             ovf_d, ovf_q;
    logic             zero_d, zero_q;
    logic [WIDTH-1:0] final_d;

    // Flags are formed from the operands entering the top slice and its sum,
    // so they are captured on the same edge as the top slice of out_sum.
    always_comb begin
        final_d = align_d[STAGES-1];
        final_d[(STAGES-1)*SLICE +: SLICE] = slice_next[STAGES-1];
        ovf_d  = (a_d[STAGES-1][WIDTH-1] == b_d[STAGES-1][WIDTH-1]) &&
                 (final_d[WIDTH-1] != a_d[STAGES-1][WIDTH-1]);
        zero_d = (final_d == '0);
    end

    // Flag registers follow the same advance/hold rule as the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (advance) begin
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign out_overflow = ovf_q;
    assign out_zero     = zero_q;
`else
    assign out_overflow = 1'b0;
    assign out_zero     = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// Bench for pipe_adder (WIDTH=32, STAGES=4): directed vector table, stall and
// reset sequences, then randomized traffic checked by a scoreboard.
module tb_pipe_adder;

    localparam int W = 32;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] inp_a = '0, inp_b = '0;
    logic         inp_cin = 1'b0, inp_sub = 1'b0, inp_valid = 1'b0, inp_ready = 1'b1;
    logic         out_ready, out_carry, out_overflow, out_zero, out_valid;
    logic [W-1:0] out_sum;

    int n_cmp = 0;
    int n_bad = 0;

    // expected {overflow, zero, carry, sum}
    logic [W+2:0] exp_q[$];

    pipe_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk(clk), .rst_n(rst_n),
        .inp_a(inp_a), .inp_b(inp_b), .inp_cin(inp_cin), .inp_sub(inp_sub),
        .inp_valid(inp_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_carry(out_carry), .out_overflow(out_overflow),
        .out_zero(out_zero), .out_valid(out_valid), .inp_ready(inp_ready)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: two's complement arithmetic on wide integers.
    function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin, input logic sub);
        longint unsigned ua, ub, full;
        longint sa, sb, sres;
        logic ovf, zero;
        ua = a;
        ub = b;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sub) begin
            full = ua + (64'hFFFF_FFFF - ub) + 1;
            sres = sa - sb;
        end else begin
            full = ua + ub + cin;
            sres = sa + sb + cin;
        end
        full = full & 64'h1_FFFF_FFFF;
`ifdef PIPE_ADDER_FLAGS_EN
        ovf  = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
        zero = (full[W-1:0] == 0);
`else
        ovf  = 1'b0;
        zero = 1'b0;
`endif
        return {ovf, zero, full[W:0]};
    endfunction

    // scoreboard / protocol monitor, sampled mid-cycle
    logic         held_v = 1'b0;
    logic [W+2:0] held;
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            held_v = 1'b0;
        end else begin
            check("ready_rule", out_ready, !out_valid || inp_ready);
            if (held_v && out_valid)
                check("stall_stable", {out_overflow, out_zero, out_carry, out_sum}, held);
            else if (held_v)
                check("stall_valid_hold", out_valid, 1'b1);
            held_v = out_valid && !inp_ready;
            held   = {out_overflow, out_zero, out_carry, out_sum};
            if (out_valid && inp_ready) begin
                if (exp_q.size() == 0)
                    check("unexpected_result", 1'b1, 1'b0);
                else
                    check("scoreboard", {out_overflow, out_zero, out_carry, out_sum}, exp_q.pop_front());
            end
            if (inp_valid && out_ready)
                exp_q.push_back(model(inp_a, inp_b, inp_cin, inp_sub));
        end
    end

    typedef struct {
        logic [W-1:0] a, b;
        logic cin, sub;
        logic [W-1:0] sum;
        logic carry, ovf, zero;
    } vec_t;

    // Present one operand at posedge+1 with the pipe empty, measure latency, compare.
    task automatic run_vec(input vec_t v, input string name);
        int lat;
        inp_a = v.a; inp_b = v.b; inp_cin = v.cin; inp_sub = v.sub;
        inp_valid = 1'b1; inp_ready = 1'b1;
        @(posedge clk); #1;
        inp_valid = 1'b0;
        lat = 99;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        check({name, "_latency"}, lat, S);
        check({name, "_sum"}, out_sum, v.sum);
        check({name, "_carry"}, out_carry, v.carry);
`ifdef PIPE_ADDER_FLAGS_EN
        check({name, "_ovf"}, out_overflow, v.ovf);
        check({name, "_zero"}, out_zero, v.zero);
`else
        check({name, "_ovf"}, out_overflow, 1'b0);
        check({name, "_zero"}, out_zero, 1'b0);
`endif
        @(posedge clk); #1;
    endtask

    function automatic logic [W-1:0] rand_word();
        case ($urandom_range(0, 5))
            0: return 32'hFFFF_FFFF;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h0000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic rand_op();
        inp_a = rand_word(); inp_b = rand_word();
        inp_cin = 1'($urandom_range(0, 1)); inp_sub = 1'($urandom_range(0, 1));
    endtask

    task automatic drain(input string name);
        inp_valid = 1'b0; inp_ready = 1'b1;
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge clk);
        #1;
        check(name, exp_q.size(), 0);
    endtask

    vec_t vecs[8];

    initial begin
        int sent, cyc, stall_seen;
        logic acc;

        vecs[0] = '{32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1};
        vecs[1] = '{32'h5,         32'h7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{32'h0,         32'h0, 1'b1, 1'b0, 32'h1,         1'b0, 1'b0, 1'b0};
        vecs[4] = '{32'h7,         32'h7, 1'b1, 1'b1, 32'h0,         1'b1, 1'b0, 1'b1};
        vecs[5] = '{32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{32'h0000_FFFF, 32'h1, 1'b1, 1'b0, 32'h0001_0001, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};

        // reset values, before any clock edge matters
        #2;
        check("reset_valid", out_valid, 1'b0);
        check("reset_sum", out_sum, 32'h0);
        check("reset_ready", out_ready, 1'b1);
        check("reset_carry", out_carry, 1'b0);
        check("reset_flags", {out_overflow, out_zero}, 2'b00);

        // release right after an edge; first acceptance at the next edge
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_vec(vecs[0], "first_after_reset");

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

        // eight back-to-back operands with downstream stalled on cycles 3-5
        sent = 0; cyc = 0; stall_seen = 0;
        rand_op();
        while (sent < 8 && cyc < 60) begin
            inp_ready = !(cyc >= 3 && cyc <= 5);
            inp_valid = 1'b1;
            @(negedge clk);
            acc = out_ready;
            if (!out_ready) stall_seen++;
            @(posedge clk); #1;
            if (acc) begin
                sent++;
                rand_op();
            end
            cyc++;
        end
        check("stall_all_sent", sent, 8);
        check("stall_ready_low_seen", stall_seen > 0, 1'b1);
        drain("stall_drain");

        // three operations in flight, downstream blocked, then async reset
        inp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_op();
            inp_valid = 1'b1;
            @(posedge clk); #1;
        end
        inp_valid = 1'b0;
        for (int k = 0; k < 10 && !out_valid; k++) begin
            @(posedge clk); #1;
        end
        check("inflight_valid", out_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_valid", out_valid, 1'b0);
        check("midreset_sum", out_sum, 32'h0);
        check("midreset_ready", out_ready, 1'b1);
        check("midreset_carry", out_carry, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_vec(vecs[2], "after_midreset");
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("no_stale_result", out_valid, 1'b0);
        end
        @(posedge clk); #1;

        // randomized traffic with random back-pressure
        for (int c = 0; c < 600; c++) begin
            rand_op();
            inp_valid = ($urandom_range(0, 3) != 0);
            inp_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        drain("random_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // global time limit
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "timeout");
    end

endmodule
